// File: rtl/complex_multiplier_pkg.sv
// Shared widths, the complex beat layout and the scale/saturate helper
// for the streaming complex multiplier.
package complex_multiplier_pkg;

    localparam int INTEGER_WIDTH_DEF    = 8;
    localparam int FRACTIONAL_WIDTH_DEF = 8;
    localparam int W = INTEGER_WIDTH_DEF + FRACTIONAL_WIDTH_DEF;

    // Imaginary part occupies the upper half of a beat, real part the lower half.
    typedef struct packed {
        logic signed [W-1:0] im;
        logic signed [W-1:0] re;
    } cplx_t;

    // Floor-shift by fw, then clamp to the signed w-bit range.
    // The result sits in the low w bits; valid for 2*w+1 <= 64.
    function automatic logic signed [63:0] sat_shift(input logic signed [63:0] x,
                                                     input int fw, input int w);
        logic signed [63:0] s;
        logic signed [63:0] mx;
        logic signed [63:0] mn;
        s  = x >>> fw;
        mx = (64'sd1 <<< (w - 1)) - 64'sd1;
        mn = -(64'sd1 <<< (w - 1));
        if (s > mx)      return mx;
        else if (s < mn) return mn;
        else             return s;
    endfunction

endpackage

// File: rtl/complex_multiplier_pipe.sv
// Three-stage signed complex multiply (operand regs, partial products,
// combine + scale + saturate). The whole pipe advances only on ce.
module cplx_mult_pipe
    import complex_multiplier_pkg::*;
#(
    parameter int IW = INTEGER_WIDTH_DEF,
    parameter int FW = FRACTIONAL_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ce,
    input  logic                    in_valid,
    input  logic [2*(IW+FW)-1:0]    a_data,
    input  logic [2*(IW+FW)-1:0]    b_data,
    output logic                    out_valid,
    output logic [2*(IW+FW)-1:0]    out_data
);
    localparam int CW     = IW + FW;
    localparam int STAGES = 3;

    logic [STAGES:1]         vld_pipe_q, vld_pipe_d;
    logic signed [CW-1:0]    ar_q, ai_q, br_q, bi_q;
    logic signed [CW-1:0]    ar_d, ai_d, br_d, bi_d;
    logic signed [2*CW-1:0]  p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    logic signed [2*CW-1:0]  p_rr_d, p_ii_d, p_ri_d, p_ir_d;
    logic [2*CW-1:0]         prod_q, prod_d;
    logic signed [2*CW:0]    re_full, im_full;
    logic signed [63:0]      re_sat, im_sat;
    logic                    unused_sat_hi;

    // One extra bit keeps the sum/difference of two full products exact.
    always_comb begin
        re_full = {p_rr_q[2*CW-1], p_rr_q} - {p_ii_q[2*CW-1], p_ii_q};
        im_full = {p_ri_q[2*CW-1], p_ri_q} + {p_ir_q[2*CW-1], p_ir_q};
        re_sat  = sat_shift({{(63-2*CW){re_full[2*CW]}}, re_full}, FW, CW);
        im_sat  = sat_shift({{(63-2*CW){im_full[2*CW]}}, im_full}, FW, CW);
    end

    assign unused_sat_hi = ^{re_sat[63:CW], im_sat[63:CW]};

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        ar_d   = ar_q;
        ai_d   = ai_q;
        br_d   = br_q;
        bi_d   = bi_q;
        p_rr_d = p_rr_q;
        p_ii_d = p_ii_q;
        p_ri_d = p_ri_q;
        p_ir_d = p_ir_q;
        prod_d = prod_q;
        if (ce) begin
            vld_pipe_d = {vld_pipe_q[STAGES-1:1], in_valid};
            ar_d   = a_data[CW-1:0];
            ai_d   = a_data[2*CW-1:CW];
            br_d   = b_data[CW-1:0];
            bi_d   = b_data[2*CW-1:CW];
            p_rr_d = ar_q * br_q;
            p_ii_d = ai_q * bi_q;
            p_ri_d = ar_q * bi_q;
            p_ir_d = ai_q * br_q;
            prod_d = {im_sat[CW-1:0], re_sat[CW-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            ar_q   <= '0;
            ai_q   <= '0;
            br_q   <= '0;
            bi_q   <= '0;
            p_rr_q <= '0;
            p_ii_q <= '0;
            p_ri_q <= '0;
            p_ir_q <= '0;
            prod_q <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            ar_q   <= ar_d;
            ai_q   <= ai_d;
            br_q   <= br_d;
            bi_q   <= bi_d;
            p_rr_q <= p_rr_d;
            p_ii_q <= p_ii_d;
            p_ri_q <= p_ri_d;
            p_ir_q <= p_ir_d;
            prod_q <= prod_d;
        end
    end

    assign out_valid = vld_pipe_q[STAGES];
    assign out_data  = prod_q;

endmodule

// File: rtl/complex_multiplier_axis.sv
// Streaming complex multiplier: joins one A and one B beat into one
// product beat, with the pipeline stalled by downstream backpressure.
module complex_multiplier_axis
    import complex_multiplier_pkg::*;
#(
    parameter int INTEGER_WIDTH    = INTEGER_WIDTH_DEF,
    parameter int FRACTIONAL_WIDTH = FRACTIONAL_WIDTH_DEF
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          input_a_tvalid,
    output logic                                          input_a_tready,
    input  logic [2*(INTEGER_WIDTH+FRACTIONAL_WIDTH)-1:0] input_a_tdata,
    input  logic                                          input_b_tvalid,
    output logic                                          input_b_tready,
    input  logic [2*(INTEGER_WIDTH+FRACTIONAL_WIDTH)-1:0] input_b_tdata,
    output logic                                          output_prod_tvalid,
    input  logic                                          output_prod_tready,
    output logic [2*(INTEGER_WIDTH+FRACTIONAL_WIDTH)-1:0] output_prod_tdata
);
    logic ce;
    logic accept;

    // Both sides are taken in the same cycle or not at all.
    assign ce             = !output_prod_tvalid || output_prod_tready;
    assign accept         = ce && input_a_tvalid && input_b_tvalid && rst_n;
    assign input_a_tready = accept;
    assign input_b_tready = accept;

    cplx_mult_pipe #(
        .IW (INTEGER_WIDTH),
        .FW (FRACTIONAL_WIDTH)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .in_valid  (accept),
        .a_data    (input_a_tdata),
        .b_data    (input_b_tdata),
        .out_valid (output_prod_tvalid),
        .out_data  (output_prod_tdata)
    );

endmodule

// File: tb/tb_complex_multiplier_axis.sv
// Self-checking bench for complex_multiplier_axis (Q8.8 defaults).
module tb_complex_multiplier_axis;
    localparam int W  = 16;
    localparam int FW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_valid, b_valid, p_ready;
    logic          a_ready, b_ready, p_valid;
    logic [2*W-1:0] a_data, b_data, p_data;

    int n_cmp = 0;
    int n_err = 0;
    logic [2*W-1:0] exp_q[$];

    always #5 clk = ~clk;

    complex_multiplier_axis dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .input_a_tvalid     (a_valid),
        .input_a_tready     (a_ready),
        .input_a_tdata      (a_data),
        .input_b_tvalid     (b_valid),
        .input_b_tready     (b_ready),
        .input_b_tdata      (b_data),
        .output_prod_tvalid (p_valid),
        .output_prod_tready (p_ready),
        .output_prod_tdata  (p_data)
    );

    function automatic longint floor_scale(input longint x);
        longint d;
        longint q;
        d = longint'(1) << FW;
        q = x / d;
        if ((x % d) != 0 && x < 0) q = q - 1;
        return q;
    endfunction

    function automatic logic [W-1:0] clamp(input longint x);
        longint mx;
        longint mn;
        longint y;
        mx = (longint'(1) << (W - 1)) - 1;
        mn = -(longint'(1) << (W - 1));
        y  = (x > mx) ? mx : ((x < mn) ? mn : x);
        return W'(y);
    endfunction

    // Reference: complex product with exact integers, floor scaling, clamping.
    function automatic logic [2*W-1:0] ref_prod(input logic [2*W-1:0] a, input logic [2*W-1:0] b);
        longint ar, ai, br, bi;
        ar = longint'($signed(a[W-1:0]));
        ai = longint'($signed(a[2*W-1:W]));
        br = longint'($signed(b[W-1:0]));
        bi = longint'($signed(b[2*W-1:W]));
        return {clamp(floor_scale(ar*bi + ai*br)), clamp(floor_scale(ar*br - ai*bi))};
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1; p_ready = 1'b1;
        a_data = $urandom; b_data = $urandom;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL reset_a_tready got %b want 0", a_ready); end
        n_cmp++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL reset_b_tready got %b want 0", b_ready); end
        n_cmp++; if (p_valid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got %b want 0", p_valid); end
        n_cmp++; if (p_data !== '0) begin n_err++; $display("FAIL reset_tdata got %h want 0", p_data); end
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [2*W-1:0] va[6];
        logic [2*W-1:0] vb[6];
        logic [2*W-1:0] vp[6];
        int lat;
        bit seen;
        va = '{32'h0200_0100, 32'h0100_0000, 32'h0000_0080, 32'h0000_FFFF, 32'h0000_7F00, 32'h0000_8000};
        vb = '{32'h0400_0300, 32'h0100_0000, 32'h0000_0080, 32'h0000_0080, 32'h0000_7F00, 32'h0000_7F00};
        vp = '{32'h0A00_FB00, 32'h0000_FF00, 32'h0000_0040, 32'h0000_FFFF, 32'h0000_7FFF, 32'h0000_8000};
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            a_data = va[i]; b_data = vb[i]; a_valid = 1'b1; b_valid = 1'b1; p_ready = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (a_ready !== 1'b1 || b_ready !== 1'b1)
                begin n_err++; $display("FAIL dir%0d_accept got %b%b want 11", i, a_ready, b_ready); end
            lat = 0; seen = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(posedge clk); #1;
                a_valid = 1'b0; b_valid = 1'b0;
                @(negedge clk);
                lat++;
                if (p_valid) seen = 1'b1;
            end
            n_cmp++;
            if (!seen || lat != 3) begin n_err++; $display("FAIL dir%0d_latency got %0d want 3", i, lat); end
            n_cmp++;
            if (p_data !== vp[i]) begin n_err++; $display("FAIL dir%0d_data got %h want %h", i, p_data, vp[i]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_join;
        logic [2*W-1:0] e;
        int cnt;
        a_data = $urandom; b_data = $urandom; p_ready = 1'b1;
        a_valid = 1'b1; b_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (a_ready !== 1'b0 || b_ready !== 1'b0 || p_valid !== 1'b0)
                begin n_err++; $display("FAIL join_wait%0d got rdy %b%b vld %b want 000", c, a_ready, b_ready, p_valid); end
            @(posedge clk); #1;
        end
        b_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1)
            begin n_err++; $display("FAIL join_accept got %b%b want 11", a_ready, b_ready); end
        e = ref_prod(a_data, b_data);
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (p_valid && p_ready) begin
                cnt++;
                n_cmp++;
                if (p_data !== e) begin n_err++; $display("FAIL join_data got %h want %h", p_data, e); end
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (cnt != 1) begin n_err++; $display("FAIL join_count got %0d want 1", cnt); end
    endtask

    task automatic test_backpressure;
        int sent, got, cyc;
        bit pending;
        logic prev_stall;
        logic [2*W-1:0] prev_data, e;
        sent = 0; got = 0; cyc = 0; pending = 1'b0; prev_stall = 1'b0; prev_data = '0;
        exp_q.delete();
        while (got < 20 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if (!pending && sent < 20 && $urandom_range(3) != 0) begin
                a_data = $urandom; b_data = $urandom;
                if ($urandom_range(1) == 1) begin a_data = a_data & 32'h03FF_03FF; b_data = b_data & 32'h83FF_83FF; end
                pending = 1'b1;
            end
            a_valid = pending; b_valid = pending;
            p_ready = 1'($urandom_range(1));
            @(negedge clk);
            n_cmp++;
            if (b_ready !== a_ready) begin n_err++; $display("FAIL bp_join got b %b want a %b", b_ready, a_ready); end
            if (a_valid && a_ready) begin
                exp_q.push_back(ref_prod(a_data, b_data));
                sent++; pending = 1'b0;
            end
            if (prev_stall) begin
                n_cmp++;
                if (p_valid !== 1'b1 || p_data !== prev_data)
                    begin n_err++; $display("FAIL bp_hold got %b/%h want 1/%h", p_valid, p_data, prev_data); end
            end
            if (p_valid && p_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL bp_extra got %h want none", p_data);
                end else begin
                    e = exp_q.pop_front();
                    if (p_data !== e) begin n_err++; $display("FAIL bp_data%0d got %h want %h", got, p_data, e); end
                end
                got++;
            end
            prev_stall = p_valid && !p_ready;
            prev_data  = p_data;
        end
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0; p_ready = 1'b1;
        n_cmp++;
        if (got != 20 || sent != 20 || exp_q.size() != 0)
            begin n_err++; $display("FAIL bp_count got %0d/%0d left %0d want 20/20 left 0", got, sent, exp_q.size()); end
    endtask

    task automatic test_back_to_back;
        int cnt, first, last;
        logic [2*W-1:0] e;
        cnt = 0; first = -1; last = -1;
        exp_q.delete();
        p_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            a_valid = (k < 10); b_valid = (k < 10);
            a_data = $urandom; b_data = $urandom;
            @(negedge clk);
            if (k < 10) begin
                n_cmp++;
                if (a_ready !== 1'b1) begin n_err++; $display("FAIL b2b_accept%0d got %b want 1", k, a_ready); end
            end
            if (a_valid && a_ready) exp_q.push_back(ref_prod(a_data, b_data));
            if (p_valid) begin
                if (first < 0) first = k;
                last = k;
                cnt++;
                n_cmp++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                if (p_data !== e) begin n_err++; $display("FAIL b2b_data%0d got %h want %h", cnt, p_data, e); end
            end
        end
        n_cmp++;
        if (cnt != 10 || last - first != 9)
            begin n_err++; $display("FAIL b2b_rate got %0d beats over %0d cycles want 10 over 10", cnt, last - first + 1); end
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [2*W-1:0] e;
        int cnt;
        p_ready = 1'b1;
        @(posedge clk); #1;
        a_data = $urandom; b_data = $urandom; a_valid = 1'b1; b_valid = 1'b1;
        @(posedge clk); #1;
        a_data = $urandom; b_data = $urandom;
        @(posedge clk); #1;
        rst_n = 1'b0;
        a_data = $urandom; b_data = $urandom;
        @(negedge clk);
        n_cmp++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0)
            begin n_err++; $display("FAIL rstmid_tready got %b%b want 00", a_ready, b_ready); end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (p_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_tvalid got %b want 0", p_valid); end
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        a_data = $urandom; b_data = $urandom; a_valid = 1'b1; b_valid = 1'b1;
        e = ref_prod(a_data, b_data);
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (p_valid) begin
                cnt++;
                n_cmp++;
                if (p_data !== e) begin n_err++; $display("FAIL rstmid_data got %h want %h", p_data, e); end
            end
            @(posedge clk); #1;
            a_valid = 1'b0; b_valid = 1'b0;
        end
        n_cmp++;
        if (cnt != 1) begin n_err++; $display("FAIL rstmid_count got %0d want 1", cnt); end
    endtask

    initial begin
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; p_ready = 1'b0;
        a_data = '0; b_data = '0;
        test_reset();
        test_directed();
        test_join();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
